// File: rtl/pll_reset_supervisor.sv
// PLL reset supervisor: pulses the PLL reset, waits for a stable lock,
// then releases a downstream reset; restarts the PLL on lock loss or request.
//
// Ports:
//   clk_sys_i      free-running system clock (independent of the PLL)
//   rst_n_i        synchronous active-low reset
//   pll_locked_i   PLL lock flag, asynchronous to clk_sys_i
//   force_relock_i single-cycle request to restart the PLL
//   pll_rst_o      active-high reset to the PLL
//   rst_n_o        active-low reset to PLL-clocked logic (high only in RUN)
//   pll_ok_o       high only in RUN
//   relock_cnt_o   saturating count of lock losses plus forced relocks
//   timeout_cnt_o  saturating count of lock timeouts

module pll_reset_supervisor #(
    parameter int g_pll_rst_cycles  = 16,
    parameter int g_lock_timeout    = 65536,
    parameter int g_stable_cycles   = 1024,
    parameter int g_rst_hold_cycles = 32
) (
    input  logic       clk_sys_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       force_relock_i,
    output logic       pll_rst_o,
    output logic       rst_n_o,
    output logic       pll_ok_o,
    output logic [7:0] relock_cnt_o,
    output logic [7:0] timeout_cnt_o
);

    localparam int c_max_ab = (g_pll_rst_cycles > g_lock_timeout)
                            ? g_pll_rst_cycles : g_lock_timeout;
    localparam int c_max_cd = (g_stable_cycles > g_rst_hold_cycles)
                            ? g_stable_cycles : g_rst_hold_cycles;
    localparam int c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int c_cw     = $clog2(c_max + 1);

    typedef logic [c_cw-1:0] cnt_t;

    localparam cnt_t c_rst_load    = cnt_t'(g_pll_rst_cycles);
    localparam cnt_t c_lock_load   = cnt_t'(g_lock_timeout);
    localparam cnt_t c_stable_load = cnt_t'(g_stable_cycles);
    localparam cnt_t c_hold_load   = cnt_t'(g_rst_hold_cycles);
    localparam cnt_t c_one         = cnt_t'(1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN
    } state_t;

    state_t state;
    state_t state_nx;
    cnt_t   cnt;
    cnt_t   cnt_nx;
    cnt_t   cnt_dec;
    logic   last;
    logic   sync1;
    logic   locked_s;
    logic   relock_inc;
    logic   timeout_inc;

    assign cnt_dec = cnt - c_one;
    // The shared counter is loaded with the phase length on entry, so the
    // phase ends on the edge where it still reads one.
    assign last    = (cnt == c_one);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        relock_inc  = 1'b0;
        timeout_inc = 1'b0;
        // A forced relock outranks every other exit, including a
        // simultaneous lock loss, so only one increment happens.
        if (force_relock_i && state != S_PLL_RST) begin
            state_nx   = S_PLL_RST;
            cnt_nx     = c_rst_load;
            relock_inc = 1'b1;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (last) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = c_lock_load;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nx = S_STABLE;
                        cnt_nx   = c_stable_load;
                    end else if (last) begin
                        state_nx    = S_PLL_RST;
                        cnt_nx      = c_rst_load;
                        timeout_inc = 1'b1;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                S_STABLE: begin
                    // A glitch during acquisition is not a relock event.
                    if (!locked_s) begin
                        state_nx = S_WAIT_LOCK;
                        cnt_nx   = c_lock_load;
                    end else if (last) begin
                        state_nx = S_HOLD;
                        cnt_nx   = c_hold_load;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                S_HOLD: begin
                    if (!locked_s) begin
                        state_nx   = S_PLL_RST;
                        cnt_nx     = c_rst_load;
                        relock_inc = 1'b1;
                    end else if (last) begin
                        state_nx = S_RUN;
                    end else begin
                        cnt_nx = cnt_dec;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_nx   = S_PLL_RST;
                        cnt_nx     = c_rst_load;
                        relock_inc = 1'b1;
                    end
                end
                default: begin
                    state_nx = S_PLL_RST;
                    cnt_nx   = c_rst_load;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            sync1         <= 1'b0;
            locked_s      <= 1'b0;
            state         <= S_PLL_RST;
            cnt           <= c_rst_load;
            pll_rst_o     <= 1'b1;
            rst_n_o       <= 1'b0;
            pll_ok_o      <= 1'b0;
            relock_cnt_o  <= 8'd0;
            timeout_cnt_o <= 8'd0;
        end else begin
            sync1     <= pll_locked_i;
            locked_s  <= sync1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            pll_rst_o <= (state_nx == S_PLL_RST);
            rst_n_o   <= (state_nx == S_RUN);
            pll_ok_o  <= (state_nx == S_RUN);
            if (relock_inc && relock_cnt_o != 8'hFF) begin
                relock_cnt_o <= relock_cnt_o + 8'd1;
            end
            if (timeout_inc && timeout_cnt_o != 8'hFF) begin
                timeout_cnt_o <= timeout_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Testbench for pll_reset_supervisor: directed scenarios with a
// timestamp-based reference model checked every cycle.

module tb_pll_reset_supervisor;

    localparam int P = 4;
    localparam int T = 100;
    localparam int S = 8;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       force_r = 1'b0;
    logic       pll_rst;
    logic       rst_n_out;
    logic       pll_ok;
    logic [7:0] relock_cnt;
    logic [7:0] timeout_cnt;

    always #5 clk = ~clk;

    pll_reset_supervisor #(
        .g_pll_rst_cycles (P),
        .g_lock_timeout   (T),
        .g_stable_cycles  (S),
        .g_rst_hold_cycles(H)
    ) dut (
        .clk_sys_i     (clk),
        .rst_n_i       (rst_n),
        .pll_locked_i  (locked),
        .force_relock_i(force_r),
        .pll_rst_o     (pll_rst),
        .rst_n_o       (rst_n_out),
        .pll_ok_o      (pll_ok),
        .relock_cnt_o  (relock_cnt),
        .timeout_cnt_o (timeout_cnt)
    );

    int tests  = 0;
    int failed = 0;
    int n      = -1000;
    int base   = 0;

    // Reference model: phase plus entry timestamp; phase lengths are
    // checked as elapsed edges since entry. Lock is seen two edges late.
    typedef enum {M_RST, M_WAIT, M_STAB, M_HOLD, M_RUN} mphase_t;
    mphase_t ph = M_RST;
    int  t_ent = 0;
    int  m_rc  = 0;
    int  m_tc  = 0;
    bit  mvalid = 1'b0;
    bit  lh[$];

    always @(posedge clk) begin : model
        bit ls;
        int el;
        n = n + 1;
        if (!rst_n) begin
            ph = M_RST;
            t_ent = n;
            m_rc = 0;
            m_tc = 0;
            lh.delete();
        end else begin
            lh.push_back(locked);
            ls = (lh.size() >= 3) ? lh[lh.size()-3] : 1'b0;
            if (lh.size() > 3) void'(lh.pop_front());
            el = n - t_ent;
            if (force_r && ph != M_RST) begin
                ph = M_RST;
                t_ent = n;
                m_rc = (m_rc < 255) ? m_rc + 1 : 255;
            end else begin
                case (ph)
                    M_RST: if (el == P) begin ph = M_WAIT; t_ent = n; end
                    M_WAIT: begin
                        if (ls) begin
                            ph = M_STAB; t_ent = n;
                        end else if (el == T) begin
                            ph = M_RST; t_ent = n;
                            m_tc = (m_tc < 255) ? m_tc + 1 : 255;
                        end
                    end
                    M_STAB: begin
                        if (!ls) begin ph = M_WAIT; t_ent = n; end
                        else if (el == S) begin ph = M_HOLD; t_ent = n; end
                    end
                    M_HOLD: begin
                        if (!ls) begin
                            ph = M_RST; t_ent = n;
                            m_rc = (m_rc < 255) ? m_rc + 1 : 255;
                        end else if (el == H) begin
                            ph = M_RUN; t_ent = n;
                        end
                    end
                    M_RUN: begin
                        if (!ls) begin
                            ph = M_RST; t_ent = n;
                            m_rc = (m_rc < 255) ? m_rc + 1 : 255;
                        end
                    end
                    default: ph = M_RST;
                endcase
            end
        end
        mvalid = 1'b1;
    end

    always @(negedge clk) begin : compare
        logic e_prst;
        logic e_run;
        if (mvalid) begin
            e_prst = (ph == M_RST);
            e_run  = (ph == M_RUN);
            tests++;
            if (pll_rst !== e_prst || rst_n_out !== e_run ||
                pll_ok !== e_run || relock_cnt !== 8'(m_rc) ||
                timeout_cnt !== 8'(m_tc)) begin
                failed++;
                $display("FAIL model_cmp edge %0d: got prst=%b rstn=%b ok=%b rc=%0d tc=%0d, need prst=%b rstn=%b ok=%b rc=%0d tc=%0d",
                         n - base, pll_rst, rst_n_out, pll_ok, relock_cnt,
                         timeout_cnt, e_prst, e_run, e_run, m_rc, m_tc);
            end
        end
    end

    // Edge-event recorder for the literal timing checks.
    logic prev_prst = 1'bx;
    logic prev_rstn = 1'bx;
    int   prst_rise = -1;
    int   prst_rise_prev = -1;
    int   prst_fall = -1;
    int   rstn_rise = -1;
    int   rstn_fall = -1;
    bit   rstn_ever = 1'b0;

    always @(negedge clk) begin : monitor
        if (prev_prst === 1'b0 && pll_rst === 1'b1) begin
            prst_rise_prev = prst_rise;
            prst_rise = n;
        end
        if (prev_prst === 1'b1 && pll_rst === 1'b0) prst_fall = n;
        if (prev_rstn === 1'b0 && rst_n_out === 1'b1) rstn_rise = n;
        if (prev_rstn === 1'b1 && rst_n_out === 1'b0) rstn_fall = n;
        if (rst_n_out === 1'b1) rstn_ever = 1'b1;
        prev_prst = pll_rst;
        prev_rstn = rst_n_out;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    // Return at the negedge just before edge base+k, so inputs set now
    // are sampled on that edge.
    task automatic to_cycle(input int k);
        while (n < base + k - 1) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_prst", int'(pll_rst), 1);
        chk("rst_rstn", int'(rst_n_out), 0);
        chk("rst_ok", int'(pll_ok), 0);
        chk("rst_rc", int'(relock_cnt), 0);
        chk("rst_tc", int'(timeout_cnt), 0);

        // Clean lock-up from reset
        rst_n = 1'b1;
        base = n + 1;
        to_cycle(10); locked = 1'b1;
        to_cycle(30);
        chk("a_prst_fall", prst_fall - base, 3);
        chk("a_rstn_rise", rstn_rise - base, 24);
        chk("a_ok", int'(pll_ok), 1);
        chk("a_rc", int'(relock_cnt), 0);
        chk("a_tc", int'(timeout_cnt), 0);

        // One-cycle lock drop in RUN
        to_cycle(40); locked = 1'b0;
        to_cycle(41); locked = 1'b1;
        to_cycle(50);
        chk("b_rstn_fall", rstn_fall - base, 42);
        chk("b_prst_rise", prst_rise - base, 42);
        chk("b_rc", int'(relock_cnt), 1);
        to_cycle(65);
        chk("b_prst_fall", prst_fall - base, 46);
        chk("b_rstn_rise", rstn_rise - base, 59);

        // Force coinciding with synchronized lock loss
        to_cycle(70); locked = 1'b0;
        to_cycle(71); locked = 1'b1;
        to_cycle(72); force_r = 1'b1;
        to_cycle(73); force_r = 1'b0;
        to_cycle(80);
        chk("c_rc_once", int'(relock_cnt), 2);
        chk("c_rstn_fall", rstn_fall - base, 72);
        // Glitch during STABLE
        locked = 1'b0;
        to_cycle(81); locked = 1'b1;
        to_cycle(99);
        chk("d_rstn_rise", rstn_rise - base, 95);
        chk("d_rc", int'(relock_cnt), 2);
        chk("d_tc", int'(timeout_cnt), 0);

        // Force in RUN, then a second force ignored in PLL_RST
        to_cycle(100); force_r = 1'b1;
        to_cycle(101); force_r = 1'b0;
        to_cycle(102); force_r = 1'b1;
        to_cycle(103); force_r = 1'b0;
        to_cycle(110);
        chk("e_rc", int'(relock_cnt), 3);
        chk("e_prst_fall", prst_fall - base, 104);

        // Reset during HOLD
        to_cycle(115); rst_n = 1'b0;
        to_cycle(116);
        chk("f_prst", int'(pll_rst), 1);
        chk("f_rstn", int'(rst_n_out), 0);
        chk("f_ok", int'(pll_ok), 0);
        chk("f_rc", int'(relock_cnt), 0);
        chk("f_tc", int'(timeout_cnt), 0);
        locked = 1'b0;
        to_cycle(119);

        // Never locks: periodic retries and timeout saturation
        rst_n = 1'b1;
        base = n + 1;
        rstn_ever = 1'b0;
        to_cycle(320);
        chk("g_tc3", int'(timeout_cnt), 3);
        chk("g_prst_rise", prst_rise - base, 311);
        chk("g_period", prst_rise - prst_rise_prev, 104);
        to_cycle(256 * 104 + 10);
        chk("g_tc_sat", int'(timeout_cnt), 255);
        chk("g_rstn_never", int'(rstn_ever), 0);
        chk("g_rc", int'(relock_cnt), 0);

        // 300 forced relocks saturate the relock counter
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = n + 1;
        for (int i = 0; i < 300; i++) begin
            to_cycle(6 * i + 5); force_r = 1'b1;
            to_cycle(6 * i + 6); force_r = 1'b0;
            if (i == 9) chk("h_rc10", int'(relock_cnt), 10);
        end
        to_cycle(6 * 300 + 10);
        chk("h_rc_sat", int'(relock_cnt), 255);
        chk("h_tc", int'(timeout_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
